// File: rtl/term_pkg.sv
// Shared constants, types and helpers for the bit-sparsity term encoder.
package term_pkg;
  localparam int LANES  = 16;
  localparam int DATA_W = 8;
  localparam int EXP_W  = $clog2(DATA_W);

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic        [DATA_W-1:0] mag_t;
  typedef logic        [EXP_W-1:0]  exp_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // -128 wraps to 8'h80, which is exactly its unsigned magnitude
  function automatic mag_t abs_mag(operand_t v);
    return v[DATA_W-1] ? mag_t'(-v) : mag_t'(v);
  endfunction
endpackage

// File: rtl/term_encoder_if.sv
// Operand-in / term-beat-out handshake bundle of the term encoder.
interface term_encoder_if;
  import term_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [LANES-1:0][DATA_W-1:0]    in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [LANES-1:0][EXP_W-1:0]     out_exps;
  logic [LANES-1:0]                out_signs;
  logic [LANES-1:0]                out_lane_valid;
  logic                            out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_exps, out_signs, out_lane_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_exps, out_signs, out_lane_valid, out_last
  );
endinterface

// File: rtl/lead_one_detect.sv
// Per-lane leading-one finder: term exponent, flags, and residual with that term removed.
module lead_one_detect
  import term_pkg::*;
(
  input  mag_t mag,
  output exp_t idx,
  output logic nz,
  output logic single,
  output mag_t cleared
);
  always_comb begin
    idx = '0;
    // ascending scan: the highest set bit is the last one written
    for (int b = 0; b < DATA_W; b++)
      if (mag[b]) idx = exp_t'(b);
  end

  assign nz      = |mag;
  assign single  = (mag & (mag - mag_t'(1))) == '0;
  assign cleared = mag & ~(mag_t'(1) << idx);
endmodule

// File: rtl/term_encoder.sv
// Decomposes a vector of signed operands into MSB-first power-of-two term beats.
module term_encoder
  import term_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  term_encoder_if.slave bus
);
  state_t                 state_q, state_d;
  mag_t   [LANES-1:0]     r_q, r_clr;
  logic   [LANES-1:0]     s_q, nz, single;
  exp_t   [LANES-1:0]     idx;
  logic                   all_single, emit, take, capture, in_ready;

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    lead_one_detect u_lod (
      .mag     (r_q[g]),
      .idx     (idx[g]),
      .nz      (nz[g]),
      .single  (single[g]),
      .cleared (r_clr[g])
    );
  end

  assign all_single = &single;
  assign take       = emit & bus.out_ready;
  assign capture    = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = EMIT;
      EMIT: if (take && all_single) state_d = bus.in_valid ? EMIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready sees out_ready in EMIT so the next vector lands with no bubble
  always_comb begin
    emit     = (state_q == EMIT);
    in_ready = !emit || (take && all_single);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      s_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        s_q[i] <= bus.in_data[i][DATA_W-1];
        r_q[i] <= abs_mag(operand_t'(bus.in_data[i]));
      end
    end else if (take) begin
      r_q <= r_clr;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = emit;
  assign bus.out_last       = emit & all_single;
  assign bus.out_lane_valid = emit ? nz : '0;
  assign bus.out_signs      = emit ? (s_q & nz) : '0;
  assign bus.out_exps       = emit ? idx : '0;
endmodule

// File: tb/tb_term_encoder.sv
// Scoreboard bench for term_encoder: expected beats queued at stimulus, popped on acceptance.
module tb_term_encoder;
  import term_pkg::*;

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;
  typedef struct packed {
    logic [LANES-1:0][EXP_W-1:0] exps;
    logic [LANES-1:0]            signs;
    logic [LANES-1:0]            mask;
    logic                        last;
  } beat_t;

  logic clk, rst_n;
  term_encoder_if bus();
  term_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    pass_cnt = 0;
  int    total    = 0;
  beat_t exp_q[$];

  function automatic beat_t observe();
    beat_t o;
    o.exps  = bus.out_exps;
    o.signs = bus.out_signs;
    o.mask  = bus.out_lane_valid;
    o.last  = bus.out_last;
    return o;
  endfunction

  // Reference decomposition: strip the highest set bit of each magnitude per beat
  function automatic void push_model(input vec_t v);
    logic [DATA_W-1:0] r [LANES];
    logic              s [LANES];
    beat_t             b;
    logic              more;
    for (int i = 0; i < LANES; i++) begin
      s[i] = v[i][DATA_W-1];
      r[i] = s[i] ? (~v[i] + 8'd1) : v[i];
    end
    do begin
      b = '0;
      b.last = 1'b1;
      more = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (r[i] != 0) begin
          b.mask[i]  = 1'b1;
          b.signs[i] = s[i];
          if ($countones(r[i]) > 1) b.last = 1'b0;
          for (int k = DATA_W-1; k >= 0; k--)
            if (r[i][k]) begin
              b.exps[i] = exp_t'(k);
              r[i][k] = 1'b0;
              break;
            end
        end
      end
      exp_q.push_back(b);
      for (int i = 0; i < LANES; i++) if (r[i] != 0) more = 1'b1;
    end while (more);
  endfunction

  function automatic beat_t mk_lane0(input int e, input logic l);
    beat_t b = '0;
    b.mask[0] = 1'b1;
    b.exps[0] = exp_t'(e);
    b.last    = l;
    return b;
  endfunction

  // Stimulus only: present one vector for one edge while the encoder is idle
  task automatic send_one(input vec_t v);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic vec_t single_vec();
    vec_t v = '0;
    v[0] = 8'sd5;
    v[1] = -8'sd3;
    v[2] = 8'h80;
    return v;
  endfunction

  function automatic void push_single();
    beat_t b = '0;
    b.exps[0] = 3'd2; b.exps[1] = 3'd1; b.exps[2] = 3'd7;
    b.signs = 16'h0006; b.mask = 16'h0007; b.last = 1'b0;
    exp_q.push_back(b);
    b = '0;
    b.signs = 16'h0002; b.mask = 16'h0003; b.last = 1'b1;
    exp_q.push_back(b);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_hold out_valid got %b want 0", bus.out_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_lane_valid, bus.out_signs, bus.out_exps} !==
          {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 48'h0})
        $display("FAIL reset_idle cyc%0d got rdy=%b vld=%b last=%b mask=%h signs=%h exps=%h want rdy=1 rest 0",
                 c, bus.in_ready, bus.out_valid, bus.out_last, bus.out_lane_valid, bus.out_signs, bus.out_exps);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    beat_t got, e;
    int n = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push_single();
    send_one(single_vec());
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got = observe(); e = exp_q.pop_front(); total++; n++;
        if (got !== e) $display("FAIL single beat%0d got %h want %h", n, got, e);
        else pass_cnt++;
      end
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL single_count missing %0d beats want 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL single_idle got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    beat_t got, e;
    int n = 0;
    @(posedge clk); #1;
    e = '0; e.last = 1'b1;
    exp_q.push_back(e);
    send_one('0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        n++; total++;
        if (exp_q.size() == 0) $display("FAIL zero_extra beat%0d got %h want none", n, observe());
        else begin
          got = observe(); e = exp_q.pop_front();
          if (got !== e) $display("FAIL zero beat%0d got %h want %h", n, got, e);
          else pass_cnt++;
        end
      end
    end
    total++;
    if (n != 1) $display("FAIL zero_count got %0d beats want 1", n);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_127();
    beat_t got, e;
    vec_t v = '0;
    int n = 0;
    @(posedge clk); #1;
    v[0] = 8'sd127;
    for (int k = 6; k >= 0; k--) exp_q.push_back(mk_lane0(k, k == 0));
    send_one(v);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got = observe(); e = exp_q.pop_front(); total++; n++;
        if (got !== e) $display("FAIL max127 beat%0d got %h want %h", n, got, e);
        else pass_cnt++;
      end
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL max127_count missing %0d beats want 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic  pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beat_t got, prev, e;
    logic  prev_taken = 1'b1;
    int    accepted = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push_single();
    send_one(single_vec());
    for (int c = 0; c < 5; c++) begin
      bus.out_ready = pat[c];
      @(negedge clk);
      got = observe();
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL bp_valid cyc%0d got %b want 1", c, bus.out_valid);
      else pass_cnt++;
      if (!prev_taken) begin
        total++;
        if (got !== prev) $display("FAIL bp_stable cyc%0d got %h want %h", c, got, prev);
        else pass_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        accepted++;
        total++;
        if (exp_q.size() == 0) $display("FAIL bp_extra cyc%0d got %h want none", c, got);
        else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL bp_beat cyc%0d got %h want %h", c, got, e);
          else pass_cnt++;
        end
      end
      prev = got;
      prev_taken = bus.out_ready;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    total++;
    if (accepted != 2 || exp_q.size() != 0)
      $display("FAIL bp_count got %0d accepted %0d left want 2 accepted 0 left", accepted, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_idle got vld=%b want 0", bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    beat_t got, e;
    vec_t  v;
    int    idx = 0, bubbles = 0, n = 0;
    logic  acc, started = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(mk_lane0(0, 1'b1));
    exp_q.push_back(mk_lane0(1, 1'b1));
    exp_q.push_back(mk_lane0(1, 1'b0));
    exp_q.push_back(mk_lane0(0, 1'b1));
    bus.out_ready = 1'b1;
    v = '0; v[0] = 8'd1;
    bus.in_data = v; bus.in_valid = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        started = 1'b1;
        got = observe(); e = exp_q.pop_front(); total++; n++;
        if (got !== e) $display("FAIL b2b beat%0d got %h want %h", n, got, e);
        else pass_cnt++;
      end else if (started) bubbles++;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin v = '0; v[0] = DATA_W'(idx + 1); bus.in_data = v; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0 || bubbles != 0)
      $display("FAIL b2b_flow got %0d missing %0d bubbles want 0 and 0", exp_q.size(), bubbles);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    vec_t v = '0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    v[0] = 8'd3;
    send_one(v);
    @(negedge clk);
    total++;
    if (!bus.out_valid || observe() !== mk_lane0(1, 1'b0))
      $display("FAIL rst_pre vld=%b got %h want %h", bus.out_valid, observe(), mk_lane0(1, 1'b0));
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_lane_valid !== 16'h0)
      $display("FAIL rst_async got vld=%b mask=%h want 0 0", bus.out_valid, bus.out_lane_valid);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    v[0] = 8'd4;
    bus.in_data = v; bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_lane_valid !== 16'h0)
      $display("FAIL rst_after got rdy=%b vld=%b mask=%h want 1 0 0", bus.in_ready, bus.out_valid, bus.out_lane_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (!bus.out_valid || observe() !== mk_lane0(2, 1'b1))
      $display("FAIL rst_next vld=%b got %h want %h", bus.out_valid, observe(), mk_lane0(2, 1'b1));
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    localparam int N = 8;
    vec_t  vecs [N];
    beat_t got, e;
    int    idx = 0, n = 0;
    logic  acc;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < LANES; i++)
        vecs[k][i] = ($urandom_range(0, 2) == 0) ? '0 : DATA_W'($urandom);
      if (k == 0) begin vecs[k][0] = 8'h80; vecs[k][1] = 8'h7f; vecs[k][2] = 8'h81; end
      push_model(vecs[k]);
    end
    bus.in_data = vecs[0]; bus.in_valid = 1'b1;
    for (int c = 0; c < 600 && (exp_q.size() > 0 || idx < N); c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        got = observe(); total++; n++;
        if (exp_q.size() == 0) $display("FAIL rand_extra beat%0d got %h want none", n, got);
        else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL rand beat%0d got %h want %h", n, got, e);
          else pass_cnt++;
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < N) bus.in_data = vecs[idx];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    total++;
    if (exp_q.size() != 0 || idx != N)
      $display("FAIL rand_done got %0d missing %0d/%0d vectors accepted want 0 and %0d", exp_q.size(), idx, N, N);
    else pass_cnt++;
    exp_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_127();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/term_encoder.md
# term_encoder

Front-end encoder for the bit-sparsity datapath. Accepts a vector of `LANES` two's-complement operands and decomposes each lane into its non-zero power-of-two terms (exponent, sign), emitting one term per lane per beat, MSB-first. The output beats are the (exponent, sign) operand vectors that the PE exponent-add stage consumes on its A or B side. The output stream is valid/ready; the vector boundary is marked by `OUT_LAST`.

## Interface
- `LANES`, 16, lanes per vector.
- `DATA_W`, 8, operand width in two's complement. `EXP_W = $clog2(DATA_W)` = 3.
- `CLK` input 1: single clock, rising edge.
- `RSTN` input 1: reset, asynchronous, active-low.
- `IN_VALID` input 1: an input vector is offered.
- `IN_READY` output 1: the encoder accepts the offered vector.
- `IN_DATA` input `[LANES-1:0][DATA_W-1:0]`: signed operands.
- `OUT_VALID` output 1: a term beat is presented.
- `OUT_READY` input 1: the downstream consumer takes the beat.
- `OUT_EXPS` output `[LANES-1:0][EXP_W-1:0]`: the exponent of the current term in each lane.
- `OUT_SIGNS` output `[LANES-1:0]`: 1 = negative term.
- `OUT_LANE_VALID` output `[LANES-1:0]`: the lane carries a term this beat.
- `OUT_LAST` output 1: final beat of the current vector.

## Operation
- FSM states:
  - `IDLE`: `IN_READY=1`, `OUT_VALID=0`.
  - `EMIT`: `OUT_VALID=1`.
- Capture on `IN_VALID & IN_READY`:
  - Each lane stores sign `s = IN_DATA[i][DATA_W-1]` and residual magnitude `r = |IN_DATA[i]|`, held as an unsigned `DATA_W`-bit value. -128 gives `r = 8'h80` with no saturation.
  - The FSM goes to `EMIT`.
- Per-beat output, per lane:
  - `OUT_LANE_VALID[i] = (r != 0)`.
  - `OUT_EXPS[i]` = index of the leading one of `r`, and 0 when `r == 0`.
  - `OUT_SIGNS[i] = s & (r != 0)`.
- `OUT_LAST=1` when every lane's `r` has at most one bit set.
- On `OUT_VALID & OUT_READY`, each lane clears its leading-one bit in `r`.
  - If `OUT_LAST`, go to `IDLE`.
  - If `OUT_LAST` and `IN_VALID` are both high in the same cycle, capture the new vector and stay in `EMIT` (back-to-back, no bubble).
- `IN_READY = (state==IDLE) | (state==EMIT & OUT_VALID & OUT_READY & OUT_LAST)`.
- All-zero vector: exactly one beat with `OUT_LANE_VALID=0`, `OUT_LAST=1`, so downstream still observes the vector boundary.
- Beats per vector = max over lanes of popcount(`r`), with a minimum of 1 and a maximum of `DATA_W-1` (7 for 127). For -128 the lane holds a single term.
- Backpressure: with `OUT_VALID=1` and `OUT_READY=0`, all outputs and state hold stable. The residual registers do not change.
- When `OUT_READY` is continuously high, every beat is taken on the cycle it is presented.

## Timing
- Reset (`RSTN` low, asynchronous):
  - state = `IDLE`, all residuals and signs = 0.
  - `OUT_VALID=0`, `OUT_LAST=0` (gated by state), `OUT_LANE_VALID=0`, `OUT_EXPS=0`, `OUT_SIGNS=0`, `IN_READY=1` once `RSTN` is high.
- Reset mid-vector discards the remaining terms. No partial beat appears after reset deassertion.
- Latency: a vector accepted at edge t presents its first beat in the cycle after t.
- State, residual and sign registers are flops. Beat outputs are combinational from these registers only, with no combinational path from `OUT_READY` to `OUT_VALID`/data.
- `IN_READY` depends combinationally on `OUT_READY` in `EMIT`, which is required for back-to-back transfers.
- Throughput: one beat per cycle; N-beat vectors sustain one vector every N cycles.

## Structure
- Package `term_pkg` holds:
  - constants `LANES`, `DATA_W`, `EXP_W`;
  - typedefs `operand_t` (logic signed `[DATA_W-1:0]`), `mag_t` (logic `[DATA_W-1:0]`), `exp_t` (logic `[EXP_W-1:0]`);
  - the state enum `{IDLE, EMIT}`.
- One sub-module, `lead_one_detect`, instanced per lane:
  - input `mag_t`;
  - outputs `exp_t` index, `nz` flag, and a `single` flag (at most one bit set);
  - the cleared residual (`r` with its leading one removed).
- Top-level `OUT_LAST` is the AND-reduction of the lanes' `single` flags.

## Test plan
- Reset then idle:
  - stimulus: `RSTN` low, release, `IN_VALID=0` for 5 cycles;
  - required: `IN_READY=1`, `OUT_VALID=0`, all outputs 0.
- Single vector, `OUT_READY=1`, lane0=+5, lane1=-3, lane2=-128, others 0:
  - beat1: lane0 (exp2,+), lane1 (exp1,-), lane2 (exp7,-), lane-valid mask `16'h0007`, `OUT_LAST=0`;
  - beat2: lane0 (exp0,+), lane1 (exp0,-), mask `16'h0003`, `OUT_LAST=1`;
  - then `IDLE`.
- All-zero vector:
  - exactly one beat with mask 0 and `OUT_LAST=1`.
- Lane0=127, others 0:
  - seven beats with exps 6,5,4,3,2,1,0;
  - `OUT_LAST` only on the seventh beat.
- Backpressure:
  - stimulus: same vector as the single-vector case, `OUT_READY` toggled 0,0,1,0,1;
  - required: beat content held stable while stalled; exactly 2 beats accepted; no terms lost.
- Back-to-back and mid-vector reset:
  - stimulus: `IN_VALID` held high with vectors {+1}, {+2}, {+3};
  - required: beats (exp0), (exp1), (exp1), (exp0), each with the correct `OUT_LAST`, and no idle cycles;
  - then assert `RSTN` low during the {+3} vector; after release, `OUT_VALID=0` and the next input is accepted immediately.
